// File: rtl/uart_bus_bridge.sv
// Register-bus to UART bridge: TX/RX byte FIFOs, STATUS flags, one-byte-in-flight TX sequencer.
// Reads return data one cycle after bus_rd; TX writes and RX bytes are dropped (with sticky flag) when full.

module uart_bus_bridge_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_push;
    logic         w_pop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
endmodule

module uart_bus_bridge #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_data_ready,
    input  logic [7:0]  rx_data
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO} tx_state_t;

    tx_state_t   r_state;
    logic [1:0]  r_wait_cnt;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic [31:0] r_bus_rdata;
    logic        r_rx_ovr;
    logic        r_tx_ovf;

    logic        w_rd, w_wr;
    logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_idle;
    logic        w_rx_pop, w_rx_full, w_rx_empty;
    logic        w_stat_rd;
    logic [7:0]  w_tx_head, w_rx_head;
    logic [31:0] w_status;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    // Simultaneous read and write strobes are treated as no access at all.
    assign w_rd      = bus_rd & ~bus_wr;
    assign w_wr      = bus_wr & ~bus_rd;
    assign w_tx_push = w_wr & ~bus_addr;
    assign w_rx_pop  = w_rd & ~bus_addr & ~w_rx_empty;
    assign w_stat_rd = w_rd & bus_addr;
    assign w_tx_pop  = (r_state == S_IDLE) & ~w_tx_empty & ~tx_busy;
    assign w_tx_idle = w_tx_empty & (r_state == S_IDLE) & ~tx_busy;
    assign w_unused  = &{1'b0, bus_wdata[31:8]};

    uart_bus_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_tx_push),
        .i_push_dat (bus_wdata[7:0]),
        .i_pop      (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_full     (w_tx_full),
        .o_empty    (w_tx_empty)
    );

    uart_bus_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (rx_data_ready),
        .i_push_dat (rx_data),
        .i_pop      (w_rx_pop),
        .o_head_dat (w_rx_head),
        .o_full     (w_rx_full),
        .o_empty    (w_rx_empty)
    );

    assign w_status = {26'b0, r_tx_ovf, w_tx_idle, r_rx_ovr, ~w_rx_empty, w_tx_empty, w_tx_full};
    assign w_rd_mux = bus_addr ? w_status : (w_rx_empty ? 32'b0 : {24'b0, w_rx_head});

    assign bus_rdata = r_bus_rdata;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign irq       = ~w_rx_empty;

    // Flags clear after a STATUS read, but a new event in that same cycle keeps them set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_rdata <= '0;
            r_rx_ovr    <= 1'b0;
            r_tx_ovf    <= 1'b0;
        end else begin
            if (w_rd) r_bus_rdata <= w_rd_mux;
            if (rx_data_ready & w_rx_full & ~w_rx_pop) r_rx_ovr <= 1'b1;
            else if (w_stat_rd)                        r_rx_ovr <= 1'b0;
            if (w_tx_push & w_tx_full & ~w_tx_pop)     r_tx_ovf <= 1'b1;
            else if (w_stat_rd)                        r_tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_data  <= w_tx_head;
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx_start <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    // Give up after four cycles if the transmitter never acknowledges.
                    if (tx_busy)                  r_state <= S_WAIT_LO;
                    else if (r_wait_cnt == 2'd3)  r_state <= S_IDLE;
                    else                          r_wait_cnt <= r_wait_cnt + 2'd1;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
